// File: rtl/zap_mult_sequencer_if.sv
// Multiplier-side bus between zap_mult_sequencer (master) and the
// 4-multiply, 6-cycle MAC unit (slave).
interface zap_mult_sequencer_if #(
  parameter int OP_W = 5
);
  logic [OP_W-1:0] o_mul_op;
  logic            o_mul_cc;
  logic [31:0]     o_mul_rm;
  logic [31:0]     o_mul_rs;
  logic [31:0]     o_mul_rn;
  logic [31:0]     o_mul_rh;
  logic [31:0]     i_mul_rd;
  logic            i_mul_busy;

  modport master (
    output o_mul_op, o_mul_cc, o_mul_rm, o_mul_rs, o_mul_rn, o_mul_rh,
    input  i_mul_rd, i_mul_busy
  );

  modport slave (
    input  o_mul_op, o_mul_cc, o_mul_rm, o_mul_rs, o_mul_rn, o_mul_rh,
    output i_mul_rd, i_mul_busy
  );
endinterface

// File: rtl/zap_mult_sequencer.sv
// Issue/sequencing stage for the 32x32 multiply-accumulate unit.
// Accepts MUL/MLA/UMULL/UMLAL/SMULL/SMLAL, runs a low-half pass and (for
// long forms) a high-half pass, and emits registered register writes.
// Optional feature macro: ZAP_MULT_SEQ_WATCHDOG_EN (abort a pass that sees
// no result within 10 cycles and pulse o_timeout).
module zap_mult_sequencer #(
  parameter int PHY_REGS = 46,
  parameter int ALU_OPS  = 32,
  parameter int NOP_OP   = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_clear,
  input  logic                        i_data_stall,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [2:0]                  i_op,
  input  logic                        i_cc_satisfied,
  input  logic [31:0]                 i_rm,
  input  logic [31:0]                 i_rs,
  input  logic [31:0]                 i_acc_lo,
  input  logic [31:0]                 i_acc_hi,
  input  logic [$clog2(PHY_REGS)-1:0] i_rd_lo,
  input  logic [$clog2(PHY_REGS)-1:0] i_rd_hi,
  zap_mult_sequencer_if.master        mul_if,
  output logic                        o_wb_valid,
  output logic [$clog2(PHY_REGS)-1:0] o_wb_index,
  output logic [31:0]                 o_wb_data,
  output logic                        o_done,
  output logic                        o_timeout
);

  localparam int IDX_W = $clog2(PHY_REGS);
  localparam int OP_W  = $clog2(ALU_OPS);

  // Opcodes shared with the ALU decode.
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(NOP_OP);
  localparam logic [OP_W-1:0] UMLALL = OP_W'(16);
  localparam logic [OP_W-1:0] UMLALH = OP_W'(17);
  localparam logic [OP_W-1:0] SMLALL = OP_W'(18);
  localparam logic [OP_W-1:0] SMLALH = OP_W'(19);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_LO = 2'd1,
    RUN_HI = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      rm_q, rs_q, rn_q, rh_q;
  logic [IDX_W-1:0] rd_lo_q, rd_hi_q;
  logic             long_q, signed_q;
  logic             seen_busy;
  logic             wb_valid_q, done_q;

  logic running, accept, launch, capture, final_pass, wd_expire;
  logic op_legal, op_long, op_signed, op_acc_lo, op_acc_hi;

  // Decode of the offered instruction.
  always_comb begin
    op_legal  = (i_op <= 3'd5);
    op_long   = (i_op >= 3'd2) && op_legal;
    op_signed = (i_op == 3'd4) || (i_op == 3'd5);
    op_acc_lo = (i_op == 3'd1) || (i_op == 3'd3) || (i_op == 3'd5);
    op_acc_hi = (i_op == 3'd3) || (i_op == 3'd5);
  end

  // Handshake qualifiers shared by the FSM and datapath.
  always_comb begin
    running    = (state != IDLE);
    accept     = (state == IDLE) && i_valid && o_ready && !i_clear;
    launch     = accept && i_cc_satisfied && op_legal;
    capture    = running && !i_data_stall && seen_busy && !mul_if.i_mul_busy;
    final_pass = (state == RUN_HI) || !long_q;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; flush wins over everything, stall freezes the FSM.
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else if (!i_data_stall) begin
      unique case (state)
        IDLE:   if (launch) state_nxt = RUN_LO;
        RUN_LO: begin
          if (capture)        state_nxt = long_q ? RUN_HI : IDLE;
          else if (wd_expire) state_nxt = IDLE;
        end
        RUN_HI: if (capture || wd_expire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: ready in IDLE, half-result opcode while a pass runs.
  always_comb begin
    o_ready         = 1'b0;
    mul_if.o_mul_op = OP_NOP;
    mul_if.o_mul_cc = 1'b0;
    unique case (state)
      IDLE:   o_ready = !i_data_stall && i_reset_n;
      RUN_LO: if (i_reset_n && !i_clear) begin
        mul_if.o_mul_op = signed_q ? SMLALL : UMLALL;
        mul_if.o_mul_cc = 1'b1;
      end
      RUN_HI: if (i_reset_n && !i_clear) begin
        mul_if.o_mul_op = signed_q ? SMLALH : UMLALH;
        mul_if.o_mul_cc = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand and destination latches, loaded on every accepted instruction.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rm_q     <= '0;
      rs_q     <= '0;
      rn_q     <= '0;
      rh_q     <= '0;
      rd_lo_q  <= '0;
      rd_hi_q  <= '0;
      long_q   <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      rm_q     <= i_rm;
      rs_q     <= i_rs;
      rn_q     <= op_acc_lo ? i_acc_lo : '0;
      rh_q     <= op_acc_hi ? i_acc_hi : '0;
      rd_lo_q  <= i_rd_lo;
      rd_hi_q  <= i_rd_hi;
      long_q   <= op_long;
      signed_q <= op_signed;
    end
  end

  assign mul_if.o_mul_rm = rm_q;
  assign mul_if.o_mul_rs = rs_q;
  assign mul_if.o_mul_rn = rn_q;
  assign mul_if.o_mul_rh = rh_q;

  // Tracks that the multiplier went busy, so the idle level before launch
  // is not mistaken for a finished result.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      seen_busy <= 1'b0;
    end else if (!i_data_stall) begin
      if (!running || capture || wd_expire) seen_busy <= 1'b0;
      else if (mul_if.i_mul_busy)           seen_busy <= 1'b1;
    end
  end

  // Write request register; a request caught by a stall is held and shown
  // once the stall lifts, a flush drops it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (capture) begin
      wb_valid_q <= 1'b1;
      done_q     <= final_pass;
    end else if (!i_data_stall) begin
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end
  end

  // Write index/data captured with the result.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_wb_index <= '0;
      o_wb_data  <= '0;
    end else if (capture && !i_clear) begin
      o_wb_index <= (state == RUN_HI) ? rd_hi_q : rd_lo_q;
      o_wb_data  <= mul_if.i_mul_rd;
    end
  end

  assign o_wb_valid = wb_valid_q && !i_data_stall;
  assign o_done     = done_q && !i_data_stall;

`ifdef ZAP_MULT_SEQ_WATCHDOG_EN
  logic [3:0] wd_cnt;

  assign wd_expire = running && !i_data_stall && !i_clear && !capture &&
                     (wd_cnt == 4'd9);

  // Per-pass cycle counter; expiry aborts the pass with a one-cycle flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= wd_expire;
      if (!i_data_stall) begin
        if (!running || capture || wd_expire) wd_cnt <= '0;
        else                                  wd_cnt <= wd_cnt + 4'd1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_zap_mult_sequencer.sv
// Directed testbench for zap_mult_sequencer with a small 6-cycle MAC model.
module tb_zap_mult_sequencer;

  localparam logic [4:0] NOP    = 5'd0;
  localparam logic [4:0] UMLALL = 5'd16;
  localparam logic [4:0] UMLALH = 5'd17;
  localparam logic [4:0] SMLALL = 5'd18;
  localparam logic [4:0] SMLALH = 5'd19;

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_clear, i_data_stall, i_valid, i_cc_satisfied;
  logic        o_ready, o_wb_valid, o_done, o_timeout;
  logic [2:0]  i_op;
  logic [31:0] i_rm, i_rs, i_acc_lo, i_acc_hi, o_wb_data;
  logic [5:0]  i_rd_lo, i_rd_hi, o_wb_index;

  zap_mult_sequencer_if #(.OP_W(5)) mif ();

  zap_mult_sequencer #(.PHY_REGS(46), .ALU_OPS(32), .NOP_OP(0)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(i_clear),
    .i_data_stall(i_data_stall), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_cc_satisfied(i_cc_satisfied), .i_rm(i_rm), .i_rs(i_rs),
    .i_acc_lo(i_acc_lo), .i_acc_hi(i_acc_hi), .i_rd_lo(i_rd_lo),
    .i_rd_hi(i_rd_hi), .mul_if(mif), .o_wb_valid(o_wb_valid),
    .o_wb_index(o_wb_index), .o_wb_data(o_wb_data), .o_done(o_done),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Multiplier model: launches on a non-NOP op when idle, busy for five
  // cycles, result presented with busy low on the sixth.
  int          m_cnt;
  logic [31:0] m_rd;
  logic        stuck;

  function automatic logic [31:0] mac(input logic [4:0] op, input logic [31:0] rm, rs, rn, rh);
    logic [63:0] a, b, p;
    logic        sgn;
    sgn = (op == SMLALL) || (op == SMLALH);
    a = sgn ? {{32{rm[31]}}, rm} : {32'b0, rm};
    b = sgn ? {{32{rs[31]}}, rs} : {32'b0, rs};
    p = a * b + {rh, rn};
    return ((op == UMLALH) || (op == SMLALH)) ? p[63:32] : p[31:0];
  endfunction

  always @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      m_cnt <= 0;
    end else if (!i_data_stall) begin
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end else if (mif.o_mul_cc && mif.o_mul_op != NOP) begin
        m_cnt <= 6;
        m_rd  <= mac(mif.o_mul_op, mif.o_mul_rm, mif.o_mul_rs, mif.o_mul_rn, mif.o_mul_rh);
      end
    end
  end

  assign mif.i_mul_busy = stuck || (m_cnt > 1);
  assign mif.i_mul_rd   = m_rd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle logs of one instruction, cycle 0 = accept cycle.
  int          n_wb;
  int          wb_cyc [4];
  logic [5:0]  wb_idx [4];
  logic [31:0] wb_dat [4];
  logic        wb_done[4];
  logic [4:0]  op_log [40];
  logic        rdy_log[40];
  logic        to_log [40];

  task automatic issue(input logic [2:0] op, input logic cc, input logic [31:0] rm, rs,
                       input logic [31:0] alo, ahi, input logic [5:0] rdl, rdh,
                       input int ncyc, input int clear_at, input int st_from, input int st_to);
    n_wb = 0;
    for (int k = 0; k < 40; k++) begin
      op_log[k] = NOP; rdy_log[k] = 1'b0; to_log[k] = 1'b0;
    end
    @(negedge i_clk);
    i_valid = 1'b1; i_op = op; i_cc_satisfied = cc; i_rm = rm; i_rs = rs;
    i_acc_lo = alo; i_acc_hi = ahi; i_rd_lo = rdl; i_rd_hi = rdh;
    i_clear = 1'b0; i_data_stall = 1'b0;
    #1 check("accept_ready", o_ready, 1'b1);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge i_clk);
      i_valid      = 1'b0;
      i_clear      = (c == clear_at);
      i_data_stall = (c >= st_from) && (c <= st_to);
      #1;
      op_log[c]  = mif.o_mul_op;
      rdy_log[c] = o_ready;
      to_log[c]  = o_timeout;
      if (o_wb_valid && n_wb < 4) begin
        wb_cyc[n_wb] = c; wb_idx[n_wb] = o_wb_index;
        wb_dat[n_wb] = o_wb_data; wb_done[n_wb] = o_done;
        n_wb++;
      end
    end
    @(negedge i_clk);
    i_clear = 1'b0; i_data_stall = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  int s_rdy, s_op, s_to;

  initial begin
    i_reset_n = 1'b0; i_clear = 1'b0; i_data_stall = 1'b0; i_valid = 1'b0;
    i_op = '0; i_cc_satisfied = 1'b0; i_rm = '0; i_rs = '0; i_acc_lo = '0;
    i_acc_hi = '0; i_rd_lo = '0; i_rd_hi = '0; stuck = 1'b0; m_rd = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 1'b0);
    check("rst_wb_valid", o_wb_valid, 1'b0);
    check("rst_mul_op", mif.o_mul_op, NOP);
    check("rst_done", o_done, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_ready", o_ready, 1'b1);
    check("post_rst_rm", mif.o_mul_rm, 32'h0);
    check("post_rst_cc", mif.o_mul_cc, 1'b0);

    // MUL 3*5 -> r7
    issue(3'd0, 1'b1, 32'd3, 32'd5, 32'h55, 32'h66, 6'd7, 6'd9, 20, -1, 99, 0);
    check("mul_nwb", n_wb, 1);
    check("mul_cyc", wb_cyc[0], 8);
    check("mul_idx", wb_idx[0], 6'd7);
    check("mul_dat", wb_dat[0], 32'h0000000F);
    check("mul_done", wb_done[0], 1'b1);
    check("mul_rdy7", rdy_log[7], 1'b0);
    check("mul_rdy8", rdy_log[8], 1'b1);
    check("mul_op1", op_log[1], UMLALL);
    check("mul_op8", op_log[8], NOP);
    check("mul_rn", mif.o_mul_rn, 32'h0);

    // UMLAL 0xFFFFFFFF*2 + {1,1}
    issue(3'd3, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd1, 6'd3, 6'd4, 20, -1, 99, 0);
    check("umlal_nwb", n_wb, 2);
    check("umlal_cyc0", wb_cyc[0], 8);
    check("umlal_idx0", wb_idx[0], 6'd3);
    check("umlal_dat0", wb_dat[0], 32'hFFFFFFFF);
    check("umlal_done0", wb_done[0], 1'b0);
    check("umlal_cyc1", wb_cyc[1], 15);
    check("umlal_idx1", wb_idx[1], 6'd4);
    check("umlal_dat1", wb_dat[1], 32'h00000002);
    check("umlal_done1", wb_done[1], 1'b1);
    check("umlal_rdy14", rdy_log[14], 1'b0);
    check("umlal_rdy15", rdy_log[15], 1'b1);
    check("umlal_op8", op_log[8], UMLALH);
    check("umlal_rn", mif.o_mul_rn, 32'd1);
    check("umlal_rh", mif.o_mul_rh, 32'd1);

    // SMULL -2*3
    issue(3'd4, 1'b1, 32'hFFFFFFFE, 32'd3, 32'h77, 32'h88, 6'd10, 6'd11, 20, -1, 99, 0);
    check("smull_nwb", n_wb, 2);
    check("smull_dat0", wb_dat[0], 32'hFFFFFFFA);
    check("smull_dat1", wb_dat[1], 32'hFFFFFFFF);
    check("smull_op1", op_log[1], SMLALL);
    check("smull_op8", op_log[8], SMLALH);
    check("smull_op15", op_log[15], NOP);
    check("smull_rh", mif.o_mul_rh, 32'h0);

    // MLA with condition failed
    issue(3'd1, 1'b0, 32'd6, 32'd7, 32'd1, 32'd0, 6'd5, 6'd0, 20, -1, 99, 0);
    s_rdy = 0; s_op = 0;
    for (int c = 1; c <= 20; c++) begin
      s_rdy += int'(rdy_log[c]);
      s_op  += int'(op_log[c] != NOP);
    end
    check("mla_cc0_nwb", n_wb, 0);
    check("mla_cc0_ready", s_rdy, 20);
    check("mla_cc0_op", s_op, 0);

    // Illegal opcode is consumed silently
    issue(3'd6, 1'b1, 32'd6, 32'd7, 32'd0, 32'd0, 6'd5, 6'd6, 12, -1, 99, 0);
    check("illegal_nwb", n_wb, 0);
    check("illegal_rdy1", rdy_log[1], 1'b1);

    // UMULL 5*7 flushed at cycle 10
    issue(3'd2, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 6'd12, 6'd13, 20, 10, 99, 0);
    check("clr_nwb", n_wb, 1);
    check("clr_cyc0", wb_cyc[0], 8);
    check("clr_dat0", wb_dat[0], 32'h00000023);
    check("clr_rdy10", rdy_log[10], 1'b0);
    check("clr_rdy11", rdy_log[11], 1'b1);
    check("clr_op10", op_log[10], NOP);

    // MUL 4*4 with stall over cycles 7-9
    issue(3'd0, 1'b1, 32'd4, 32'd4, 32'd0, 32'd0, 6'd20, 6'd0, 20, -1, 7, 9);
    check("stall_nwb", n_wb, 1);
    check("stall_cyc", wb_cyc[0], 11);
    check("stall_dat", wb_dat[0], 32'h00000010);
    check("stall_done", wb_done[0], 1'b1);

    // Multiplier busy stuck high
    stuck = 1'b1;
`ifdef ZAP_MULT_SEQ_WATCHDOG_EN
    issue(3'd0, 1'b1, 32'd2, 32'd2, 32'd0, 32'd0, 6'd21, 6'd0, 16, -1, 99, 0);
    s_to = 0;
    for (int c = 1; c <= 16; c++) s_to += int'(to_log[c]);
    check("wd_to10", to_log[10], 1'b0);
    check("wd_to11", to_log[11], 1'b1);
    check("wd_to_count", s_to, 1);
    check("wd_rdy11", rdy_log[11], 1'b1);
    check("wd_nwb", n_wb, 0);
`else
    issue(3'd0, 1'b1, 32'd2, 32'd2, 32'd0, 32'd0, 6'd21, 6'd0, 22, 20, 99, 0);
    s_to = 0;
    for (int c = 1; c <= 22; c++) s_to += int'(to_log[c]);
    check("stuck_to_count", s_to, 0);
    check("stuck_rdy19", rdy_log[19], 1'b0);
    check("stuck_rdy21", rdy_log[21], 1'b1);
    check("stuck_nwb", n_wb, 0);
`endif
    stuck = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
